msg_serializer: RTL and testbench
=================================

MSG_SERIALIZER -- requirements
Module: msg_serializer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5: the frame start byte sent ahead of every message.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 16: idle clocks inserted after each frame (legal range 0..65535).
REQ-003 The block SHALL have port CLK  input  1  sole clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port FIFO_EMPTY  input  1  the downstream message FIFO (written by the arbiter) is empty.
REQ-006 The block SHALL have port FIFO_RD_DATA  input  128  FIFO read data, valid the cycle after FIFO_READ.
REQ-007 The block SHALL have port FIFO_READ  output  1  single-cycle FIFO pop strobe.
REQ-008 The block SHALL have port UART_READY  input  1  UART can accept a byte.
REQ-009 The block SHALL have port UART_LOAD  output  1  single-cycle byte load strobe.
REQ-010 The block SHALL have port UART_DATA  output  8  byte to transmit; valid whenever UART_LOAD=1.
REQ-011 The block SHALL have port BUSY  output  1  a frame is in progress (any state other than IDLE).
REQ-012 The block SHALL have port MSG_COUNT  output  16  count of fully sent frames; wraps 16'hFFFF->0.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, POP, LATCH, SEND, HOLD, GAP.
- IDLE: if FIFO_EMPTY=0, go to POP.
- POP: assert FIFO_READ for exactly this one cycle, then go to LATCH.
- LATCH: capture FIFO_RD_DATA into a 128-bit message register, clear the byte index and checksum, then go to SEND.
REQ-014 A frame SHALL be 18 bytes, sent in this order:
- index 0 = SYNC_BYTE;
- indices 1..16 = message bits [127:120] down to [7:0] (MSB byte first);
- index 17 = XOR of the 16 message bytes (SYNC_BYTE excluded).
REQ-015 SEND: when UART_READY=1, assert UART_LOAD for one cycle with UART_DATA set to the current byte, advance the index and go to HOLD; while UART_READY=0, stay in SEND with UART_LOAD=0.
REQ-016 HOLD SHALL last exactly one cycle and ignore UART_READY, so two loads are at least 2 cycles apart. This allows the UART's registered READY drop to take effect. From HOLD:
- if index < 18, go to SEND;
- otherwise increment MSG_COUNT and go to GAP.
REQ-017 GAP SHALL count GAP_CYCLES clocks and then return to IDLE; with GAP_CYCLES=0 it SHALL last 1 cycle.
REQ-018 Minimum frame-start-to-frame-start time SHALL be 3 + 18*2 + max(GAP_CYCLES,1) + 1 cycles; with the default this is 56.
REQ-019 FIFO_READ SHALL never assert outside POP, so there is at most one pop per frame and never a pop while FIFO_EMPTY=1.
REQ-020 FIFO_EMPTY changes during a frame SHALL be ignored; it is sampled only in IDLE.
REQ-021 UART_DATA SHALL hold its last value when UART_LOAD=0; it carries no meaning then.
REQ-022 The checksum SHALL accumulate byte by byte as each data byte is loaded, not be recomputed combinationally over 128 bits.

Reset
REQ-023 While RESET=1 at a clock edge, the state SHALL become IDLE and all of the following SHALL become 0: FIFO_READ, UART_LOAD, UART_DATA, BUSY, MSG_COUNT, byte index, checksum, gap counter and message register.
REQ-024 RESET asserted mid-frame SHALL abort the frame with no further UART_LOAD and no MSG_COUNT increment. The popped message is lost.
REQ-025 The first FIFO_READ after RESET deasserts SHALL come no earlier than 2 cycles later (IDLE, then POP).

Structure
REQ-026 A shared package SHALL hold:
- state encoding (3 bits);
- the frame length constant 18;
- the data byte count 16;
- the SYNC_BYTE default.
REQ-027 The block SHALL be a single module with no sub-module. The byte selection is a 5-bit-index mux over the message register, SYNC and checksum.

Verification
REQ-028 Single frame: message 128'h00112233_44556677_8899AABB_CCDDEEFF with UART_READY tied to 1 -> FIFO_READ pulses once. Bytes are A5,00,11,...,FF,00; checksum = XOR of the 16 bytes = 8'h00. Loads are spaced 2 cycles apart and MSG_COUNT becomes 1.
REQ-029 Back-pressure: drop UART_READY for 10 cycles before byte 5 -> UART_LOAD is held low, no byte is skipped or repeated, and the byte order is unchanged.
REQ-030 Back-to-back: 3 messages queued with GAP_CYCLES=16 -> there are exactly 3 FIFO_READ pulses, each 56 cycles apart, and MSG_COUNT=3.
REQ-031 Reset mid-frame: RESET for 1 cycle after byte 7 -> no further loads, MSG_COUNT=0, and the next queued message is sent as a complete frame starting with A5.
REQ-032 Wrap/boundary: preload MSG_COUNT=16'hFFFF via forced state and send one frame -> MSG_COUNT=0. Repeat with GAP_CYCLES=0 -> 1 gap cycle and no FIFO_READ while FIFO_EMPTY=1.

Source files
------------

// File: rtl/msg_serializer_pkg.sv
// Shared definitions for the message serializer: state encoding, frame geometry
// and the default sync byte.
package msg_serializer_pkg;

    // Frame sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    // Bytes on the wire per frame: sync + 16 data bytes + checksum.
    localparam int FRAME_LEN = 18;

    // Data bytes carried by one 128-bit message.
    localparam int DATA_BYTES = 16;

    // Default frame start byte.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/msg_serializer_if.sv
// FIFO-side and UART-side signals of the message serializer.
//
// Handshakes: the FIFO side is pop-on-strobe -- FIFO_READ is a one-cycle pop
// issued only while FIFO_EMPTY=0, and FIFO_RD_DATA is valid the cycle after.
// The UART side is valid/ready -- a byte transfers on a cycle where
// UART_LOAD=1; UART_LOAD is only raised from a state that saw UART_READY=1,
// and UART_DATA is meaningful only while UART_LOAD=1.
interface msg_serializer_if;
    import msg_serializer_pkg::*;

    logic         FIFO_EMPTY;
    logic [127:0] FIFO_RD_DATA;
    logic         FIFO_READ;
    logic         UART_READY;
    logic         UART_LOAD;
    logic [7:0]   UART_DATA;

    // Serializer side.
    modport master (
        input  FIFO_EMPTY,
        input  FIFO_RD_DATA,
        input  UART_READY,
        output FIFO_READ,
        output UART_LOAD,
        output UART_DATA
    );

    // FIFO / UART side.
    modport slave (
        output FIFO_EMPTY,
        output FIFO_RD_DATA,
        output UART_READY,
        input  FIFO_READ,
        input  UART_LOAD,
        input  UART_DATA
    );

endinterface

// File: rtl/msg_serializer.sv
// Pops 128-bit messages from a FIFO and sends each as an 18-byte UART frame:
// sync byte, 16 message bytes MSB first, XOR checksum of the message bytes.
// A configurable idle gap follows every frame.
module msg_serializer
    import msg_serializer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter int         GAP_CYCLES = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    msg_serializer_if.master       bus,
    output logic                   BUSY,
    output logic [15:0]            MSG_COUNT,
    output state_t                 STATE
);

    localparam logic [4:0]  LAST_IDX    = 5'(FRAME_LEN - 1);
    localparam logic [4:0]  FRAME_LEN_W = 5'(FRAME_LEN);
    // GAP runs while the counter walks 0..GAP_LAST, i.e. GAP_CYCLES+1 clocks,
    // and a single clock when GAP_CYCLES is 0.
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES);

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  msg_reg;
    logic [4:0]    byte_idx;
    logic [7:0]    checksum;
    logic [15:0]   gap_cnt;
    logic [15:0]   msg_count_q;
    logic          uart_load_q;
    logic [7:0]    uart_data_q;
    logic [7:0]    cur_byte;

    logic          fifo_read;
    logic          do_latch;
    logic          do_load;
    logic          do_count;

    // Next-state and per-state control strobes.
    always_comb begin
        state_nxt = state;
        fifo_read = 1'b0;
        do_latch  = 1'b0;
        do_load   = 1'b0;
        do_count  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.FIFO_EMPTY) state_nxt = POP;
            end
            POP: begin
                fifo_read = 1'b1;
                state_nxt = LATCH;
            end
            LATCH: begin
                do_latch  = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (bus.UART_READY) begin
                    do_load   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (byte_idx < FRAME_LEN_W) begin
                    state_nxt = SEND;
                end else begin
                    do_count  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte selected by the frame index: sync, message bytes MSB first, checksum.
    always_comb begin
        cur_byte = SYNC_BYTE;
        if (byte_idx == LAST_IDX) begin
            cur_byte = checksum;
        end else begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (byte_idx == 5'(i + 1)) cur_byte = msg_reg[8*(DATA_BYTES-1-i) +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Message capture, byte index and running checksum of loaded data bytes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            msg_reg  <= '0;
            byte_idx <= '0;
            checksum <= '0;
        end else if (do_latch) begin
            msg_reg  <= bus.FIFO_RD_DATA;
            byte_idx <= '0;
            checksum <= '0;
        end else if (do_load) begin
            byte_idx <= byte_idx + 5'd1;
            if (byte_idx != 5'd0 && byte_idx != LAST_IDX) checksum <= checksum ^ cur_byte;
        end
    end

    // UART load strobe and data; data keeps its last value between loads.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            uart_load_q <= 1'b0;
            uart_data_q <= '0;
        end else begin
            uart_load_q <= do_load;
            if (do_load) uart_data_q <= cur_byte;
        end
    end

    // Inter-frame gap counter, restarted on the way into GAP.
    always_ff @(posedge CLK) begin
        if (RESET)                gap_cnt <= '0;
        else if (do_count)        gap_cnt <= '0;
        else if (state == GAP)    gap_cnt <= gap_cnt + 16'd1;
    end

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge CLK) begin
        if (RESET)         msg_count_q <= '0;
        else if (do_count) msg_count_q <= msg_count_q + 16'd1;
    end

    assign bus.FIFO_READ = fifo_read;
    assign bus.UART_LOAD = uart_load_q;
    assign bus.UART_DATA = uart_data_q;
    assign BUSY          = (state != IDLE);
    assign MSG_COUNT     = msg_count_q;
    assign STATE         = state;

endmodule

// File: tb/tb_msg_serializer.sv
// Bench for msg_serializer: directed scenarios with random message payloads,
// a FIFO model feeding each instance and a frame-level reference of the bytes
// that must appear on the UART side.
module tb_msg_serializer;
    import msg_serializer_pkg::*;

    localparam logic [7:0] SYNC = 8'hA5;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESET;
    int   cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    msg_serializer_if if_a ();
    msg_serializer_if if_b ();

    logic        busy_a, busy_b;
    logic [15:0] msg_count_a, msg_count_b;
    state_t      st_a, st_b;

    msg_serializer #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(16)) dut_a (
        .CLK(CLK), .RESET(RESET), .bus(if_a), .BUSY(busy_a),
        .MSG_COUNT(msg_count_a), .STATE(st_a)
    );

    msg_serializer #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .bus(if_b), .BUSY(busy_b),
        .MSG_COUNT(msg_count_b), .STATE(st_b)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte k of the frame for message m.
    function automatic logic [7:0] frame_byte(input logic [127:0] m, input int k);
        logic [7:0] x;
        x = 8'h00;
        if (k == 0) return SYNC;
        if (k == FRAME_LEN - 1) begin
            for (int j = 0; j < DATA_BYTES; j++) x ^= m[127 - 8*j -: 8];
            return x;
        end
        return m[127 - 8*(k-1) -: 8];
    endfunction

    function automatic logic [127:0] rand_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- FIFO + UART models, instance A ----------------
    logic [127:0] fifo_a[$];
    logic [7:0]   exp_a[$];
    int           pops_a = 0, loads_a = 0, last_load_a = 0, first_load_a = 0;
    int           pop_cyc_a[$];
    logic [7:0]   first_byte_a = 8'h00, last_byte_a = 8'h00;

    assign if_a.FIFO_EMPTY = (fifo_a.size() == 0);

    always @(negedge CLK) begin
        if (RESET) begin
            exp_a.delete();
            loads_a <= 0;
        end else begin
            if (if_a.FIFO_READ) begin
                check("a_pop_while_empty", 32'(fifo_a.size() != 0), 32'd1);
                if (fifo_a.size() != 0) begin
                    logic [127:0] m;
                    m = fifo_a.pop_front();
                    if_a.FIFO_RD_DATA <= m;
                    for (int k = 0; k < FRAME_LEN; k++) exp_a.push_back(frame_byte(m, k));
                end
                pops_a  <= pops_a + 1;
                loads_a <= 0;
                pop_cyc_a.push_back(cyc);
            end
            if (if_a.UART_LOAD) begin
                if (loads_a > 0) check("a_load_spacing", 32'(cyc - last_load_a >= 2), 32'd1);
                check("a_byte_expected", 32'(exp_a.size() != 0), 32'd1);
                if (exp_a.size() != 0) check("a_byte", 32'(if_a.UART_DATA), 32'(exp_a.pop_front()));
                if (loads_a == 0) begin
                    first_byte_a <= if_a.UART_DATA;
                    first_load_a <= cyc;
                end
                last_byte_a <= if_a.UART_DATA;
                last_load_a <= cyc;
                loads_a     <= loads_a + 1;
            end
        end
    end

    // ---------------- FIFO + UART models, instance B ----------------
    logic [127:0] fifo_b[$];
    logic [7:0]   exp_b[$];
    int           pops_b = 0, loads_b = 0, gap_b = 0;

    assign if_b.FIFO_EMPTY = (fifo_b.size() == 0);

    always @(negedge CLK) begin
        if (RESET) begin
            exp_b.delete();
            loads_b <= 0;
        end else begin
            if (st_b == GAP) gap_b <= gap_b + 1;
            if (if_b.FIFO_READ) begin
                check("b_pop_while_empty", 32'(fifo_b.size() != 0), 32'd1);
                if (fifo_b.size() != 0) begin
                    logic [127:0] m;
                    m = fifo_b.pop_front();
                    if_b.FIFO_RD_DATA <= m;
                    for (int k = 0; k < FRAME_LEN; k++) exp_b.push_back(frame_byte(m, k));
                end
                pops_b  <= pops_b + 1;
                loads_b <= 0;
            end
            if (if_b.UART_LOAD) begin
                check("b_byte_expected", 32'(exp_b.size() != 0), 32'd1);
                if (exp_b.size() != 0) check("b_byte", 32'(if_b.UART_DATA), 32'(exp_b.pop_front()));
                loads_b <= loads_b + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_count_a(input logic [15:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (msg_count_a !== target && n < budget) begin step(); n++; end
        check(tag, 32'(msg_count_a), 32'(target));
    endtask

    task automatic wait_idle_a(input int budget, input string tag);
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < budget) begin step(); n++; end
        check(tag, 32'(busy_a), 32'd0);
    endtask

    task automatic wait_loads_a(input int pops, input int loads, input int budget, input string tag);
        int n;
        n = 0;
        while (!(pops_a == pops && loads_a == loads) && n < budget) begin step(); n++; end
        check(tag, 32'(loads_a), 32'(loads));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] fixed_msg;
        int           l0, n;
        fixed_msg = 128'h00112233_44556677_8899AABB_CCDDEEFF;

        RESET = 1'b1;
        if_a.UART_READY = 1'b1;
        if_b.UART_READY = 1'b1;
        repeat (3) step();

        // Reset state.
        check("rst_fifo_read", 32'(if_a.FIFO_READ), 32'd0);
        check("rst_uart_load", 32'(if_a.UART_LOAD), 32'd0);
        check("rst_uart_data", 32'(if_a.UART_DATA), 32'd0);
        check("rst_busy",      32'(busy_a),         32'd0);
        check("rst_msg_count", 32'(msg_count_a),    32'd0);
        check("rst_state",     32'(st_a),           32'(IDLE));
        check("rst_b_count",   32'(msg_count_b),    32'd0);
        RESET = 1'b0;
        repeat (2) step();

        // Single frame with known message, UART always ready.
        fifo_a.push_back(fixed_msg);
        wait_count_a(16'd1, 200, "t1_msg_count");
        wait_idle_a(100, "t1_idle");
        check("t1_pops",       32'(pops_a),       32'd1);
        check("t1_loads",      32'(loads_a),      32'd18);
        check("t1_exp_empty",  32'(exp_a.size()), 32'd0);
        check("t1_first_sync", 32'(first_byte_a), 32'hA5);
        check("t1_checksum",   32'(last_byte_a),  32'h00);
        check("t1_load_span",  32'(last_load_a - first_load_a), 32'd34);

        // Back-pressure: UART not ready for 10 cycles ahead of byte 5.
        fifo_a.push_back(rand_msg());
        wait_loads_a(2, 5, 200, "t2_reach_byte5");
        if_a.UART_READY = 1'b0;
        l0 = loads_a;
        repeat (10) step();
        check("t2_loads_held", 32'(loads_a), 32'(l0));
        check("t2_wait_state", 32'(st_a), 32'(SEND));
        if_a.UART_READY = 1'b1;
        wait_count_a(16'd2, 200, "t2_msg_count");
        wait_idle_a(100, "t2_idle");
        check("t2_loads",     32'(loads_a),      32'd18);
        check("t2_exp_empty", 32'(exp_a.size()), 32'd0);

        // Back-to-back: three queued messages.
        repeat (3) fifo_a.push_back(rand_msg());
        wait_count_a(16'd5, 400, "t3_msg_count");
        wait_idle_a(100, "t3_idle");
        check("t3_pops", 32'(pops_a), 32'd5);
        if (pop_cyc_a.size() >= 5) begin
            check("t3_spacing_1", 32'(pop_cyc_a[3] - pop_cyc_a[2]), 32'd56);
            check("t3_spacing_2", 32'(pop_cyc_a[4] - pop_cyc_a[3]), 32'd56);
        end else begin
            check("t3_pop_log", 32'(pop_cyc_a.size()), 32'd5);
        end

        // Reset after byte 7 of a frame; the next queued message follows whole.
        fifo_a.push_back(rand_msg());
        fifo_a.push_back(rand_msg());
        wait_loads_a(6, 8, 200, "t4_reach_byte7");
        RESET = 1'b1;
        step();
        check("t4_rst_count",     32'(msg_count_a),    32'd0);
        check("t4_rst_load",      32'(if_a.UART_LOAD), 32'd0);
        check("t4_rst_busy",      32'(busy_a),         32'd0);
        check("t4_first_cycle",   32'(if_a.FIFO_READ), 32'd0);
        RESET = 1'b0;
        step();
        check("t4_second_cycle",  32'(if_a.FIFO_READ), 32'd1);
        wait_count_a(16'd1, 200, "t4_msg_count");
        wait_idle_a(100, "t4_idle");
        check("t4_pops",       32'(pops_a),       32'd7);
        check("t4_loads",      32'(loads_a),      32'd18);
        check("t4_first_sync", 32'(first_byte_a), 32'hA5);
        check("t4_exp_empty",  32'(exp_a.size()), 32'd0);

        // Counter wrap from 16'hFFFF.
        force dut_a.msg_count_q = 16'hFFFF;
        step();
        release dut_a.msg_count_q;
        step();
        check("t5_preload", 32'(msg_count_a), 32'hFFFF);
        fifo_a.push_back(rand_msg());
        wait_count_a(16'd0, 200, "t5_wrap");
        wait_idle_a(100, "t5_idle");
        check("t5_exp_empty", 32'(exp_a.size()), 32'd0);

        // Zero-gap instance with random UART back-pressure.
        fifo_b.push_back(rand_msg());
        fifo_b.push_back(rand_msg());
        n = 0;
        while (!(msg_count_b == 16'd2 && busy_b == 1'b0) && n < 600) begin
            if_b.UART_READY = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        if_b.UART_READY = 1'b1;
        check("t6_msg_count",  32'(msg_count_b),  32'd2);
        check("t6_pops",       32'(pops_b),       32'd2);
        check("t6_gap_cycles", 32'(gap_b),        32'd2);
        check("t6_loads",      32'(loads_b),      32'd18);
        check("t6_exp_empty",  32'(exp_b.size()), 32'd0);
        repeat (30) step();
        check("t6_no_pop_empty", 32'(pops_b), 32'd2);
        check("t6_idle_state",   32'(st_b),   32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
